gpio_stream_out_bridge: RTL and testbench
=========================================

// Module: gpio_stream_out_bridge
// PURPOSE
//  Downstream stage of the spectrometer DSP chain in the user project.
//  Accepts 16-bit spectrum words (valid/ready/last) from the core, buffers them in a FIFO and drives the GPIO output port:
//  - data on mprj_io[23:8], last on [24], valid on [25]
//  - ready is taken from [26], which is an input pin.
//  Also provides word/frame counters and per-pin output enables.
// PARAMETERS
//  DATA_W     16    stream word width
//  DEPTH      16    FIFO entries (power of 2, >=2)
//  FRAME_LEN  1536  expected words per frame (between s_last pulses)
//  CNT_W      16    width of word/frame counters
// PORTS
//  clock          in   1        system clock
//  RSTB           in   1        reset, synchronous, active-high
//  s_valid        in   1        core stream valid
//  s_ready        out  1        core stream ready
//  s_data         in   DATA_W   core stream data
//  s_last         in   1        core stream last (final word of frame)
//  pin_ready      in   1        from mprj_io[26]
//  pin_valid      out  1        to mprj_io[25]
//  pin_last       out  1        to mprj_io[24]
//  pin_data       out  DATA_W   to mprj_io[23:8]
//  io_oeb         out  19       oeb for mprj_io[26:8]; bits[17:0]=0 (drive), bit18=1 (input)
//  word_cnt       out  CNT_W    words transferred on pin side, wraps at 2^CNT_W
//  frame_cnt      out  CNT_W    frames transferred on pin side (pin_last beats), wraps
//  err_frame      out  1        sticky frame-length error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: s_ready=0 during reset; pin_valid, pin_last, pin_data, word_cnt, frame_cnt, err_frame all 0; FIFO emptied.
//    io_oeb is constant and not reset-dependent.
//  - Input handshake: push when s_valid && s_ready at posedge. s_ready = !full. It does not look ahead at a same-cycle pop.
//  - FIFO stores {last,data}. Occupancy counter is 0..DEPTH. Pointers wrap modulo DEPTH.
//  - Output register stage:
//    - Load from the FIFO head when pin_valid==0, or when the pin beat completes (pin_valid && pin_ready).
//    - Latency: from empty, a word accepted at cycle N shows pin_valid=1 at cycle N+2. Back-to-back throughput is 1 word/cycle.
//  - Pin beat completes when pin_valid && pin_ready at posedge. On that edge:
//    - word_cnt +1
//    - frame_cnt +1 when pin_last=1
//  - pin_valid held high and pin_data/pin_last held stable until the beat completes; no retraction.
//  - When the FIFO is empty after a completed beat, pin_valid falls to 0; pin_data/pin_last hold their last values.
//  - Full FIFO with a simultaneous pop: the push is refused that cycle (s_ready=0); the pop proceeds.
//  - Empty FIFO with a simultaneous push: the word is written, then loaded into the output register next cycle. No bypass path.
//  - RSTB asserted mid-frame: all in-flight words are discarded and counters are cleared. No partial frame is replayed.
// CONFIGURATION
//  Macro GPIO_OUT_FRAME_CHECK_EN:
//  - Defined: an input-side beat counter is compared against FRAME_LEN, using beats that complete on s_valid && s_ready.
//    - err_frame is set if s_last=1 on a beat other than beat FRAME_LEN.
//    - err_frame is set if beat FRAME_LEN arrives with s_last=0.
//    - The counter restarts after every s_last beat, and also after beat FRAME_LEN.
//    - err_frame is cleared only by RSTB.
//  - Not defined: no checker logic is built; err_frame is tied to 0.
// STRUCTURE
//  - Package gpio_stream_pkg holds:
//    - pin index constants: OUT_DATA_LSB=8, OUT_LAST=24, OUT_VALID=25, OUT_READY=26, IN_READY=27, IN_VALID=28, IN_LAST=29, IN_DATA_LSB=30
//    - DATA_W default
//    - the OEB vector constant
//  - Sub-module stream_fifo: synchronous FIFO with parameters DATA_W+1 and DEPTH, and ports push/pop/full/empty/count.
//  - This module contains the output register, the counters and the optional checker.
// TESTING
//  1. Reset: hold RSTB=1 for 4 cycles with s_valid=1 -> s_ready=0, pin_valid=0, word_cnt=0, io_oeb=19'h40000.
//  2. Stream: 1536 words 0x0000..0x05FF, last on the final word, pin_ready=1 -> pin_data sequence matches exactly,
//     pin_last only on 0x05FF, word_cnt=1536, frame_cnt=1.
//  3. Backpressure: pin_ready=0 while DEPTH+1 words are offered -> s_ready=0 after 16 FIFO + 1 register words.
//     Release pin_ready -> no loss or duplication, order preserved.
//  4. Random stall: pin_ready toggled randomly at 50% and s_valid randomly at 70% over 3 frames ->
//     output equals the input sequence, frame_cnt=3, pin_data stable while pin_valid && !pin_ready.
//  5. Mid-frame reset: reset after 700 words, then send a full frame -> the first output word is the new frame's first word,
//     word_cnt=1536.
//  6. GPIO_OUT_FRAME_CHECK_EN: s_last on word 1000 -> err_frame=1 on the next cycle and remains set.
//     Without the macro: err_frame stays 0.

Source files
------------

// File: rtl/gpio_stream_pkg.sv
// Shared constants for the spectrometer GPIO stream bridge:
// mprj_io pin map, default word width and the output-enable vector.
package gpio_stream_pkg;

    localparam int STREAM_DATA_W = 16;

    localparam int OUT_DATA_LSB = 8;
    localparam int OUT_LAST     = 24;
    localparam int OUT_VALID    = 25;
    localparam int OUT_READY    = 26;
    localparam int IN_READY     = 27;
    localparam int IN_VALID     = 28;
    localparam int IN_LAST      = 29;
    localparam int IN_DATA_LSB  = 30;

    localparam int OEB_W = OUT_READY - OUT_DATA_LSB + 1;

    // Only the ready pin (mprj_io[26]) is an input; all others drive.
    localparam logic [OEB_W-1:0] OEB_VEC =
        OEB_W'(1) << (OUT_READY - OUT_DATA_LSB);

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO, power-of-two depth, occupancy 0..DEPTH.
// Push is ignored when full, pop is ignored when empty.
module stream_fifo
    import gpio_stream_pkg::*;
#(
    parameter int DATA_W = STREAM_DATA_W + 1,
    parameter int DEPTH  = 16
) (
    input  logic                       clock,
    input  logic                       RSTB,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
        if (wr_en && !rd_en) count_d = count_q + CW'(1);
        if (!wr_en && rd_en) count_d = count_q - CW'(1);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock) begin
        if (RSTB) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/gpio_stream_out_bridge.sv
// Core stream -> FIFO -> registered GPIO pins, with word/frame counters.
// Optional frame-length checker: define GPIO_OUT_FRAME_CHECK_EN.
module gpio_stream_out_bridge
    import gpio_stream_pkg::*;
#(
    parameter int DATA_W    = gpio_stream_pkg::STREAM_DATA_W,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 1536,
    parameter int CNT_W     = 16
) (
    input  logic              clock,
    input  logic              RSTB,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              pin_ready,
    output logic              pin_valid,
    output logic              pin_last,
    output logic [DATA_W-1:0] pin_data,
    output logic [OEB_W-1:0]  io_oeb,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              err_frame
);

    localparam int FW = DATA_W + 1;

    logic                       fifo_full, fifo_empty;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
    logic [FW-1:0]              fifo_rdata;
    logic                       push, pop, load, beat;

    logic              pin_valid_q, pin_valid_d;
    logic              pin_last_q, pin_last_d;
    logic [DATA_W-1:0] pin_data_q, pin_data_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    logic unused_ok;
    assign unused_ok = ^{fifo_count, 32'(FRAME_LEN)};

    assign io_oeb = OEB_VEC;

    assign s_ready = !fifo_full && !RSTB;
    assign push    = s_valid && s_ready;
    assign beat    = pin_valid_q && pin_ready;
    assign load    = !pin_valid_q || beat;
    assign pop     = load && !fifo_empty;

    stream_fifo #(
        .DATA_W (FW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock (clock),
        .RSTB  (RSTB),
        .push  (push),
        .wdata ({s_last, s_data}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Output register refill from FIFO head and pin-side beat counting.
    always_comb begin
        pin_valid_d = pin_valid_q;
        pin_last_d  = pin_last_q;
        pin_data_d  = pin_data_q;
        word_cnt_d  = word_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (load) begin
            pin_valid_d = !fifo_empty;
            if (!fifo_empty) {pin_last_d, pin_data_d} = fifo_rdata;
        end
        if (beat) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (pin_last_q) frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
    end

    // Output register and counter state.
    always_ff @(posedge clock) begin
        if (RSTB) begin
            pin_valid_q <= 1'b0;
            pin_last_q  <= 1'b0;
            pin_data_q  <= '0;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            pin_valid_q <= pin_valid_d;
            pin_last_q  <= pin_last_d;
            pin_data_q  <= pin_data_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign pin_valid = pin_valid_q;
    assign pin_last  = pin_last_q;
    assign pin_data  = pin_data_q;
    assign word_cnt  = word_cnt_q;
    assign frame_cnt = frame_cnt_q;

`ifdef GPIO_OUT_FRAME_CHECK_EN
    localparam int BW = $clog2(FRAME_LEN + 1);

    logic [BW-1:0] in_beat_q, in_beat_d, beat_num;
    logic          err_q, err_d;
    logic          at_len;

    assign beat_num = in_beat_q + BW'(1);
    assign at_len   = (beat_num == BW'(FRAME_LEN));

    // Input beat position; any last/length disagreement latches an error.
    always_comb begin
        in_beat_d = in_beat_q;
        err_d     = err_q;
        if (push) begin
            if (s_last != at_len) err_d = 1'b1;
            in_beat_d = (s_last || at_len) ? '0 : beat_num;
        end
    end

    // Checker state; the error is sticky until reset.
    always_ff @(posedge clock) begin
        if (RSTB) begin
            in_beat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            in_beat_q <= in_beat_d;
            err_q     <= err_d;
        end
    end

    assign err_frame = err_q;
`else
    assign err_frame = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_stream_out_bridge.sv
// Directed bench for gpio_stream_out_bridge.
// Frame-check expectations follow GPIO_OUT_FRAME_CHECK_EN.
module tb_gpio_stream_out_bridge;

    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int FRAME = 1536;
    localparam int MAXC  = 30000;

`ifdef GPIO_OUT_FRAME_CHECK_EN
    localparam bit EXP_ERR = 1'b1;
`else
    localparam bit EXP_ERR = 1'b0;
`endif

    logic          clock;
    logic          RSTB;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          pin_ready;
    logic          pin_valid;
    logic          pin_last;
    logic [DW-1:0] pin_data;
    logic [18:0]   io_oeb;
    logic [15:0]   word_cnt;
    logic [15:0]   frame_cnt;
    logic          err_frame;

    int checks = 0;
    int errors = 0;
    int stall_err = 0;

    logic [DW:0] out_q[$];
    bit          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    gpio_stream_out_bridge #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME),
        .CNT_W     (16)
    ) dut (
        .clock     (clock),
        .RSTB      (RSTB),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .pin_ready (pin_ready),
        .pin_valid (pin_valid),
        .pin_last  (pin_last),
        .pin_data  (pin_data),
        .io_oeb    (io_oeb),
        .word_cnt  (word_cnt),
        .frame_cnt (frame_cnt),
        .err_frame (err_frame)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pin-side monitor: collects beats, flags changes during a stall.
    always @(negedge clock) begin
        if (!RSTB) begin
            if (prev_stall && (!pin_valid || pin_data !== prev_data ||
                               pin_last !== prev_last))
                stall_err++;
            if (pin_valid && pin_ready)
                out_q.push_back({pin_last, pin_data});
            prev_stall = pin_valid && !pin_ready;
            prev_data  = pin_data;
            prev_last  = pin_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic do_reset();
        @(posedge clock); #1;
        RSTB = 1'b1;
        s_valid = 1'b0;
        s_last = 1'b0;
        pin_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1 RSTB = 1'b0;
        @(negedge clock);
        out_q.delete();
        stall_err = 0;
    endtask

    task automatic drive_stream(input int base, input int n, input int vpct,
                                input int rpct, input bit drain);
        int idx = 0;
        int cyc = 0;
        bit acc = 1'b0;
        while ((idx < n || (drain && out_q.size() < n)) && cyc < MAXC) begin
            @(posedge clock); #1;
            if (acc || !s_valid) begin
                if (idx < n && $urandom_range(99) < vpct) begin
                    s_valid = 1'b1;
                    s_data  = DW'(base + idx);
                    s_last  = ((idx % FRAME) == FRAME - 1);
                end else begin
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                end
            end
            pin_ready = ($urandom_range(99) < rpct);
            @(negedge clock);
            acc = s_valid && s_ready;
            if (acc) idx++;
            cyc++;
        end
        checks++;
        if (cyc >= MAXC) begin
            errors++;
            $display("FAIL drive_timeout: sent %0d of %0d, got %0d", idx, n,
                     out_q.size());
        end
        @(posedge clock); #1;
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic test_reset();
        RSTB = 1'b1;
        s_valid = 1'b1;
        s_data = 16'h1234;
        s_last = 1'b0;
        pin_ready = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_s_ready: got %b want 0", s_ready);
        end
        checks++;
        if (pin_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_pin_valid: got %b want 0", pin_valid);
        end
        checks++;
        if (word_cnt !== 16'd0 || frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_counts: got %0d/%0d want 0/0",
                     word_cnt, frame_cnt);
        end
        checks++;
        if (pin_data !== 16'd0 || pin_last !== 1'b0 || err_frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data %h last %b err %b want 0",
                     pin_data, pin_last, err_frame);
        end
        checks++;
        if (io_oeb !== 19'h40000) begin
            errors++;
            $display("FAIL reset_oeb: got %h want 40000", io_oeb);
        end
        #1 RSTB = 1'b0;
        s_valid = 1'b0;
        pin_ready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_latency();
        do_reset();
        @(posedge clock); #1;
        s_valid = 1'b1;
        s_data = 16'hABCD;
        @(negedge clock);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_accept: s_ready %b want 1", s_ready);
        end
        @(posedge clock); #1;
        s_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (pin_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_n1: pin_valid %b want 0", pin_valid);
        end
        @(negedge clock);
        checks++;
        if (pin_valid !== 1'b1 || pin_data !== 16'hABCD) begin
            errors++;
            $display("FAIL lat_n2: valid %b data %h want 1 abcd",
                     pin_valid, pin_data);
        end
    endtask

    task automatic test_stream();
        int bad = 0;
        do_reset();
        drive_stream(0, FRAME, 100, 100, 1'b1);
        repeat (3) @(negedge clock);
        checks++;
        if (out_q.size() != FRAME) begin
            errors++;
            $display("FAIL stream_size: got %0d want %0d", out_q.size(), FRAME);
        end
        for (int i = 0; i < out_q.size() && i < FRAME; i++)
            if (out_q[i] !== {(i == FRAME - 1), DW'(i)}) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stream_seq: %0d bad words want 0", bad);
        end
        checks++;
        if (word_cnt !== 16'(FRAME) || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL stream_cnt: got %0d/%0d want %0d/1",
                     word_cnt, frame_cnt, FRAME);
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int bad = 0;
        do_reset();
        for (int c = 0; c < 30; c++) begin
            @(posedge clock); #1;
            pin_ready = 1'b0;
            s_valid = (idx < DEPTH + 2);
            s_data = DW'(16'h0100 + idx);
            @(negedge clock);
            if (s_valid && s_ready) idx++;
        end
        checks++;
        if (idx != DEPTH + 1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: accepted %0d s_ready %b want %0d 0",
                     idx, s_ready, DEPTH + 1);
        end
        checks++;
        if (pin_valid !== 1'b1 || pin_data !== 16'h0100) begin
            errors++;
            $display("FAIL bp_hold: valid %b data %h want 1 0100",
                     pin_valid, pin_data);
        end
        for (int c = 0; c < 100 && out_q.size() < DEPTH + 2; c++) begin
            @(posedge clock); #1;
            pin_ready = 1'b1;
            s_valid = (idx < DEPTH + 2);
            s_data = DW'(16'h0100 + idx);
            @(negedge clock);
            if (s_valid && s_ready) idx++;
        end
        @(posedge clock); #1;
        s_valid = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (out_q.size() != DEPTH + 2) begin
            errors++;
            $display("FAIL bp_size: got %0d want %0d", out_q.size(), DEPTH + 2);
        end
        for (int i = 0; i < out_q.size() && i < DEPTH + 2; i++)
            if (out_q[i] !== {1'b0, DW'(16'h0100 + i)}) bad++;
        checks++;
        if (bad != 0 || word_cnt !== 16'(DEPTH + 2)) begin
            errors++;
            $display("FAIL bp_order: %0d bad, word_cnt %0d want 0 %0d",
                     bad, word_cnt, DEPTH + 2);
        end
    endtask

    task automatic test_random_stall();
        int bad = 0;
        do_reset();
        drive_stream(0, 3 * FRAME, 70, 50, 1'b1);
        pin_ready = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (out_q.size() != 3 * FRAME) begin
            errors++;
            $display("FAIL rand_size: got %0d want %0d", out_q.size(), 3 * FRAME);
        end
        for (int i = 0; i < out_q.size() && i < 3 * FRAME; i++)
            if (out_q[i] !== {((i % FRAME) == FRAME - 1), DW'(i)}) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rand_seq: %0d bad words want 0", bad);
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL rand_stable: %0d stall changes want 0", stall_err);
        end
        checks++;
        if (frame_cnt !== 16'd3 || word_cnt !== 16'(3 * FRAME)) begin
            errors++;
            $display("FAIL rand_cnt: got %0d/%0d want 3/%0d",
                     frame_cnt, word_cnt, 3 * FRAME);
        end
        checks++;
        if (err_frame !== 1'b0) begin
            errors++;
            $display("FAIL rand_err: err_frame %b want 0", err_frame);
        end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        drive_stream(16'h2000, 700, 100, 50, 1'b0);
        do_reset();
        checks++;
        if (word_cnt !== 16'd0 || pin_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_clear: word_cnt %0d valid %b want 0 0",
                     word_cnt, pin_valid);
        end
        drive_stream(16'h4000, FRAME, 100, 100, 1'b1);
        repeat (3) @(negedge clock);
        checks++;
        if (out_q.size() == 0 || out_q[0] !== {1'b0, 16'h4000}) begin
            errors++;
            $display("FAIL mid_first: got %h want 04000",
                     out_q.size() ? out_q[0] : 17'h1ffff);
        end
        checks++;
        if (word_cnt !== 16'(FRAME) || frame_cnt !== 16'd1) begin
            errors++;
            $display("FAIL mid_cnt: got %0d/%0d want %0d/1",
                     word_cnt, frame_cnt, FRAME);
        end
    endtask

    task automatic test_frame_check();
        do_reset();
        drive_stream(0, 999, 100, 100, 1'b0);
        @(posedge clock); #1;
        s_valid = 1'b1;
        s_data = 16'd999;
        s_last = 1'b1;
        pin_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (err_frame !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL fc_before: err %b ready %b want 0 1",
                     err_frame, s_ready);
        end
        @(posedge clock); #1;
        s_valid = 1'b0;
        s_last = 1'b0;
        @(negedge clock);
        checks++;
        if (err_frame !== EXP_ERR) begin
            errors++;
            $display("FAIL fc_set: err %b want %b", err_frame, EXP_ERR);
        end
        drive_stream(16'h3000, 20, 100, 100, 1'b0);
        repeat (5) @(negedge clock);
        checks++;
        if (err_frame !== EXP_ERR) begin
            errors++;
            $display("FAIL fc_sticky: err %b want %b", err_frame, EXP_ERR);
        end
        do_reset();
        checks++;
        if (err_frame !== 1'b0) begin
            errors++;
            $display("FAIL fc_clear: err %b want 0", err_frame);
        end
    endtask

    initial begin
        RSTB = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        pin_ready = 1'b0;
        test_reset();
        test_latency();
        test_stream();
        test_backpressure();
        test_random_stall();
        test_midframe_reset();
        test_frame_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
